// File: rtl/muldiv_ctrl.sv
// Iterative MULT/DIV sequencer owning the HI/LO registers; MTHI/MTLO complete in one cycle.
// Optional signed support is compiled in with `define MULDIV_SIGNED_EN (adds the FIX state).
//
//   state | meaning
//   IDLE  | ready; MTHI/MTLO execute here, MULT/DIV are accepted here
//   RUN   | one shift-add / restoring-divide step per cycle, counter down to 0
//   FIX   | apply operand signs to the magnitude result (signed build only)
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             sgn,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] OP_MULT = 2'd0;
  localparam logic [1:0] OP_DIV  = 2'd1;
  localparam logic [1:0] OP_MTHI = 2'd2;
  localparam logic [1:0] OP_MTLO = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   bop_q, bop_d;
  logic               is_div_q, is_div_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, dz_q, dz_d;

  logic               accept, last, fix_pend;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] step;

`ifdef MULDIV_SIGNED_EN
  logic neg_q, neg_d, rneg_q, rneg_d, fix_q, fix_d;
  logic sa, sb;
  assign sa       = sgn & a[WIDTH-1];
  assign sb       = sgn & b[WIDTH-1];
  assign mag_a    = sa ? -a : a;
  assign mag_b    = sb ? -b : b;
  assign fix_pend = fix_q;
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
  assign mag_a      = a;
  assign mag_b      = b;
  assign fix_pend   = 1'b0;
`endif

  assign accept = (state_q == S_IDLE) && start && !abort;
  assign last   = (cnt_q == CW'(1));

  // One iteration: low half of acc is the multiplier (MULT) or the dividend/quotient (DIV).
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, bop_q} : '0);
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = {1'b0, rem_sh} - {2'b00, bop_q};
    div_ge   = ~div_diff[WIDTH+1];
    if (is_div_q)
      step = {(div_ge ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    else
      step = {mul_sum, acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      bop_q    <= '0;
      is_div_q <= 1'b0;
      zero_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      fix_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      bop_q    <= bop_d;
      is_div_q <= is_div_d;
      zero_q   <= zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
`ifdef MULDIV_SIGNED_EN
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      fix_q    <= fix_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && (op == OP_MULT || op == OP_DIV)) state_d = S_RUN;
      S_RUN: begin
        if (abort) state_d = S_IDLE;
`ifdef MULDIV_SIGNED_EN
        else if (last) state_d = fix_pend ? S_FIX : S_IDLE;
`else
        else if (last) state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready    = (state_q == S_IDLE);
    busy     = (state_q != S_IDLE);
    done     = done_q;
    div_zero = dz_q;
    hi       = hi_q;
    lo       = lo_q;
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    bop_d    = bop_q;
    is_div_d = is_div_q;
    zero_d   = zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
`ifdef MULDIV_SIGNED_EN
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    fix_d    = fix_q;
`endif
    case (state_q)
      S_IDLE: if (accept) begin
        case (op)
          OP_MTHI: begin hi_d = a; done_d = 1'b1; end
          OP_MTLO: begin lo_d = a; done_d = 1'b1; end
          default: begin
            cnt_d    = CW'(WIDTH);
            acc_d    = {{WIDTH{1'b0}}, mag_a};
            bop_d    = mag_b;
            is_div_d = (op == OP_DIV);
            zero_d   = (op == OP_DIV) && (b == '0);
`ifdef MULDIV_SIGNED_EN
            neg_d    = sa ^ sb;
            rneg_d   = sa;
            fix_d    = sgn;
`endif
          end
        endcase
      end
      S_RUN: if (!abort) begin
        cnt_d = cnt_q - CW'(1);
        acc_d = step;
        if (last && !fix_pend) begin
          hi_d   = step[2*WIDTH-1:WIDTH];
          lo_d   = step[WIDTH-1:0];
          done_d = 1'b1;
          dz_d   = zero_q;
        end
      end
`ifdef MULDIV_SIGNED_EN
      // Divide-by-zero keeps the all-ones quotient; remainder sign restores the original a.
      S_FIX: if (!abort) begin
        if (is_div_q) begin
          lo_d = (neg_q && !zero_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
        end
        done_d = 1'b1;
        dz_d   = zero_q;
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative multiply/divide sequencer that owns the architectural HI and LO special-purpose registers. It executes MULT/DIV as a 32-step shift-add or restoring-divide loop and executes MTHI/MTLO in one cycle. It sits beside the single-cycle ALU and exposes a start/ready/done handshake so the pipeline control can stall on `busy`. MFHI/MFLO read `hi`/`lo` directly.

## Interface
- `WIDTH`, default 32: operand, HI and LO width. The iteration count equals `WIDTH`.
- `clock`  in  1  the single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request; accepted only when `ready`=1.
- `op`  in  2  operation: 0=MULT, 1=DIV, 2=MTHI, 3=MTLO.
- `sgn`  in  1  signed-operation request; sampled with `start`.
- `abort`  in  1  pipeline flush; cancels an in-flight op.
- `a`, `b`  in  WIDTH  operands. For DIV, `a` is the dividend and `b` the divisor. For MTHI/MTLO, `a` is the value written.
- `ready`  out  1  high in IDLE.
- `busy`  out  1  high in RUN or FIX.
- `done`  out  1  one-cycle pulse when HI/LO have just been updated.
- `div_zero`  out  1  pulses with `done` when a DIV had `b`=0.
- `hi`, `lo`  out  WIDTH  architectural HI/LO, registered.

## Operation
- States: IDLE, RUN, FIX.
- IDLE → RUN on an accepted MULT/DIV. RUN → FIX or IDLE after `WIDTH` iterations. FIX → IDLE.
- An accepted op latches `a`, `b`, `op` and `sgn`, and loads the counter with `WIDTH`.
- MTHI/MTLO are executed at the accept edge: `hi` (or `lo`) = `a`. The FSM stays in IDLE, `done` pulses in the next cycle, and `busy` stays 0.
- MULT: radix-2 shift-add over a 2·WIDTH working accumulator. The result is {HI,LO} = a·b (unsigned), modulo 2^(2·WIDTH).
- DIV: restoring division, one quotient bit per cycle. The result is LO = quotient and HI = remainder.
- DIV with `b`=0 needs no special case in the loop. The result is LO = all ones and HI = `a`; sign fix is skipped and `div_zero` is 1.
- Working registers are separate from `hi`/`lo`. HI/LO keep their old values until the completion edge, so MFHI/MFLO during `busy` return the previous values.
- Counter decrements once per RUN cycle. The last iteration is the one where the counter reaches 0.
- `start` while `busy` is ignored; no queueing.
- `abort` in RUN/FIX: FSM goes to IDLE at the next edge, no `done` is issued, and HI/LO are unchanged.
- `abort` and `start` together in IDLE: `abort` wins and the op is not accepted.
- `abort` on the same edge as completion: `abort` wins and HI/LO are not written.

## Timing
- Reset values: `hi`=0, `lo`=0, `done`=0, `div_zero`=0, `busy`=0, `ready`=1; state IDLE; counter 0.
- Accept edge E0.
- Unsigned MULT/DIV:
  - `busy`=1 from the cycle after E0 through edge E_WIDTH.
  - HI/LO are written at E_WIDTH.
  - `done`=1 and `ready`=1 in the cycle after E_WIDTH.
  - Latency is `WIDTH` cycles; a new `start` can be accepted in that same `done` cycle.
- Signed op (macro enabled, `sgn`=1): FIX adds one cycle. HI/LO are written at E_WIDTH+1.
- MTHI/MTLO: 1 cycle; back-to-back accepts are allowed every cycle.
- `reset` mid-operation: all outputs return to their reset values at that edge, including clearing HI/LO.

## Configuration
- `MULDIV_SIGNED_EN` defined:
  - With `sgn`=1, the op is run on operand magnitudes, then FIX applies the signs.
  - Product: negate the 2·WIDTH result if the signs differ.
  - Quotient: negated if the signs differ. Remainder: takes the dividend's sign.
  - The overflow case (-2^(WIDTH-1)) ÷ (-1) gives LO = 0x80000000 and HI = 0 (for `WIDTH`=32).
- `MULDIV_SIGNED_EN` undefined: `sgn` is ignored, all ops are unsigned, the FIX state does not exist, and latency is always `WIDTH`.

## Test plan
- Reset, then MULT `a`=0xFFFFFFFF, `b`=0x2 → `done` 32 cycles after accept, `hi`=0x1, `lo`=0xFFFFFFFE; `hi`/`lo` stay 0 while `busy`.
- DIV `a`=100, `b`=7 → `lo`=14, `hi`=2, `div_zero`=0. DIV `a`=5, `b`=0 → `lo`=0xFFFFFFFF, `hi`=5, `div_zero`=1 together with `done`.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles → `done` pulses in two consecutive cycles, `hi`=0x1234, `lo`=0x5678, `busy` never asserts.
- MULT 3×4 in progress, assert `abort` at iteration 10 → `ready` high the next cycle, no `done`, HI/LO hold their prior values. Repeat with `reset` instead → HI=LO=0.
- `start` during `busy` and `start`+`abort` together in IDLE → neither is accepted. A `start` in the `done` cycle is accepted.
- With `MULDIV_SIGNED_EN`:
  - MULT -3×5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1, 33-cycle latency.
  - DIV -7÷2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIV 0x80000000÷0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
